// File: rtl/char_buffer_arbiter.sv
// char_buffer_arbiter
// Arbitrates two character sources (UART and switches) onto a single-cell
// write port of a text character buffer. It handles backspace, carriage
// return and form feed. Form feed sweeps the whole buffer with spaces.
// Optional feature: define CHAR_ARB_ECHO_EN to add a one-entry echo register
// that returns every UART-accepted character on the tx_* channel.
module char_buffer_arbiter #(
  parameter int NUM_CHARS          = 60,
  parameter int NUM_CHARS_PER_LINE = 20,
  parameter int CHAR_WIDTH         = 8,
  localparam int AW                = $clog2(NUM_CHARS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [CHAR_WIDTH-1:0] rx_data,
  output logic                  rx_ready,
  input  logic                  sw_valid,
  input  logic [CHAR_WIDTH-1:0] sw_data,
  output logic                  sw_ready,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [CHAR_WIDTH-1:0] wr_data,
  output logic [AW-1:0]         cursor,
  output logic                  busy
`ifdef CHAR_ARB_ECHO_EN
  ,
  output logic                  tx_valid,
  output logic [CHAR_WIDTH-1:0] tx_data,
  input  logic                  tx_ready
`endif
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

  localparam logic [CHAR_WIDTH-1:0] CH_BS    = CHAR_WIDTH'(8'h08);
  localparam logic [CHAR_WIDTH-1:0] CH_CR    = CHAR_WIDTH'(8'h0D);
  localparam logic [CHAR_WIDTH-1:0] CH_FF    = CHAR_WIDTH'(8'h0C);
  localparam logic [CHAR_WIDTH-1:0] CH_SPACE = CHAR_WIDTH'(8'h20);
  localparam logic [AW-1:0]         LAST_ADDR = AW'(NUM_CHARS - 1);

  state_e                state_q, state_d;
  logic                  rr_uart_last_q, rr_uart_last_d;
  logic                  wr_en_q, wr_en_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [CHAR_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [AW-1:0]         cursor_q, cursor_d;
  logic                  busy_q, busy_d;
  logic [AW-1:0]         clr_addr_q, clr_addr_d;

  logic                  rx_elig_s;
  logic                  gnt_rx_s, gnt_sw_s;
  logic [CHAR_WIDTH-1:0] acc_data_s;
  logic [31:0]           next_line_s;

`ifdef CHAR_ARB_ECHO_EN
  logic                  tx_valid_q, tx_valid_d;
  logic [CHAR_WIDTH-1:0] tx_data_q, tx_data_d;

  // UART is held off while an un-drained echo would be overwritten
  always_comb begin
    rx_elig_s = rx_valid && !(tx_valid_q && !tx_ready);
  end
`else
  // UART eligibility depends only on its own valid
  always_comb begin
    rx_elig_s = rx_valid;
  end
`endif

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    gnt_rx_s = 1'b0;
    gnt_sw_s = 1'b0;
    if (reset && (state_q == ST_IDLE)) begin
      if (rx_elig_s && sw_valid) begin
        if (rr_uart_last_q) begin
          gnt_sw_s = 1'b1;
        end else begin
          gnt_rx_s = 1'b1;
        end
      end else if (rx_elig_s) begin
        gnt_rx_s = 1'b1;
      end else if (sw_valid) begin
        gnt_sw_s = 1'b1;
      end else begin
        gnt_rx_s = 1'b0;
      end
    end else begin
      gnt_rx_s = 1'b0;
    end
    acc_data_s = gnt_rx_s ? rx_data : sw_data;
  end

  // Start of the line following the cursor's current line
  always_comb begin
    next_line_s = ((32'(cursor_q) / 32'(NUM_CHARS_PER_LINE)) + 32'd1) * 32'(NUM_CHARS_PER_LINE);
  end

  // Next-state logic: character decode in IDLE, space sweep in CLEAR
  always_comb begin
    state_d        = state_q;
    rr_uart_last_d = rr_uart_last_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    cursor_d       = cursor_q;
    busy_d         = busy_q;
    clr_addr_d     = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_rx_s || gnt_sw_s) begin
          rr_uart_last_d = gnt_rx_s;
          case (acc_data_s)
            CH_BS: begin
              if (cursor_q != '0) begin
                cursor_d  = cursor_q - AW'(1);
                wr_en_d   = 1'b1;
                wr_addr_d = cursor_q - AW'(1);
                wr_data_d = CH_SPACE;
              end else begin
                cursor_d = cursor_q;
              end
            end
            CH_CR: begin
              if (next_line_s >= 32'(NUM_CHARS)) begin
                cursor_d = '0;
              end else begin
                cursor_d = next_line_s[AW-1:0];
              end
            end
            CH_FF: begin
              state_d    = ST_CLEAR;
              busy_d     = 1'b1;
              clr_addr_d = '0;
            end
            default: begin
              wr_en_d   = 1'b1;
              wr_addr_d = cursor_q;
              wr_data_d = acc_data_s;
              cursor_d  = (cursor_q == LAST_ADDR) ? '0 : cursor_q + AW'(1);
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_addr_q;
        wr_data_d = CH_SPACE;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          cursor_d   = '0;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, write port, cursor and arbitration pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      rr_uart_last_q <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      cursor_q       <= '0;
      busy_q         <= 1'b0;
      clr_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      rr_uart_last_q <= rr_uart_last_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      cursor_q       <= cursor_d;
      busy_q         <= busy_d;
      clr_addr_q     <= clr_addr_d;
    end
  end

`ifdef CHAR_ARB_ECHO_EN
  // Echo register: a new UART character takes precedence over draining
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (gnt_rx_s) begin
      tx_valid_d = 1'b1;
      tx_data_d  = rx_data;
    end else if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end else begin
      tx_valid_d = tx_valid_q;
    end
  end

  // Echo register storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
`endif

  assign rx_ready = gnt_rx_s;
  assign sw_ready = gnt_sw_s;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cursor   = cursor_q;
  assign busy     = busy_q;

endmodule
